// File: rtl/uart_tx_feeder_pkg.sv
// uart_tx_feeder_pkg
// Shared definitions for the UART transmit feeder: default byte width and
// FIFO depth, plus the 2-bit binary encoding of the hand-off FSM states.
package uart_tx_feeder_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if
// Groups the write-side handshake and transmitter-side signals of the feeder.
//   wr_data/wr_valid/wr_ready : byte enqueue handshake
//   tx_busy                   : transmitter frame-in-progress flag
//   tx_data/tx_data_valid     : byte and one-cycle hand-off pulse
//   fifo_count/overflow       : occupancy and sticky overflow status
// slave  = the feeder, master = the producer/transmitter side.
interface uart_tx_feeder_if
  import uart_tx_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int CNT_W      = $clog2(DEPTH + 1)
);

  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic                  tx_busy;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_data_valid;
  logic [CNT_W-1:0]      fifo_count;
  logic                  overflow;

  modport slave (
    input  wr_data, wr_valid, tx_busy,
    output wr_ready, tx_data, tx_data_valid, fifo_count, overflow
  );

  modport master (
    output wr_data, wr_valid, tx_busy,
    input  wr_ready, tx_data, tx_data_valid, fifo_count, overflow
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Synchronous FIFO with registered storage and pointers; head presents the
// entry at the registered read pointer.
//   clk, rst          : clock, synchronous active-high reset
//   push, push_data   : enqueue (ignored when full)
//   pop               : dequeue (ignored when empty)
//   head              : oldest entry
//   count, full, empty: occupancy status (full/empty decoded from count)
module uart_tx_fifo
  import uart_tx_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    wr_ptr_d = wr_ptr_q + (push_ok ? PTR_W'(1) : PTR_W'(0));
    rd_ptr_d = rd_ptr_q + (pop_ok  ? PTR_W'(1) : PTR_W'(0));
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; a flush is done by clearing the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
// Buffers bytes in a FIFO and hands them to the UART transmitter one at a
// time with a single-cycle tx_data_valid pulse, paced on tx_busy.
//   clk, rst : clock, synchronous active-high reset
//   bus      : uart_tx_feeder_if.slave (write handshake, transmitter side,
//              occupancy and sticky overflow)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | transmitter idle wait; issue when FIFO non-empty, !tx_busy
// ISSUE     | tx_data_valid high for this single cycle
// WAIT_BUSY | waiting for the transmitter to raise tx_busy
// WAIT_DONE | frame in progress, waiting for tx_busy to fall
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_feeder_if.slave  bus
);

  feeder_state_e         state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_data_valid_q, tx_data_valid_d;
  logic                  overflow_q, overflow_d;

  logic [DATA_WIDTH-1:0] head;
  logic [CNT_W-1:0]      count;
  logic                  full, empty, push, pop;

  // wr_ready uses the pre-pop count, so a write alongside a pop when full
  // is refused.
  assign push = bus.wr_valid && !full;

  uart_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .CNT_W      (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.wr_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_d         = state_q;
    pop             = 1'b0;
    tx_data_d       = tx_data_q;
    tx_data_valid_d = 1'b0;
    overflow_d      = overflow_q | (bus.wr_valid & full);
    case (state_q)
      ST_IDLE: begin
        if (!empty && !bus.tx_busy) begin
          state_d         = ST_ISSUE;
          pop             = 1'b1;
          tx_data_d       = head;
          tx_data_valid_d = 1'b1;
        end
      end
      ST_ISSUE:     state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (bus.tx_busy)  state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!bus.tx_busy) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      tx_data_q       <= '0;
      tx_data_valid_q <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      tx_data_q       <= tx_data_d;
      tx_data_valid_q <= tx_data_valid_d;
      overflow_q      <= overflow_d;
    end
  end

  assign bus.wr_ready      = !full;
  assign bus.tx_data       = tx_data_q;
  assign bus.tx_data_valid = tx_data_valid_q;
  assign bus.fifo_count    = count;
  assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

  localparam int FRAME = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_feeder_if #(.DATA_WIDTH(8), .DEPTH(8)) bus ();

  uart_tx_feeder #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Transmitter model: busy rises the cycle after capture, lasts FRAME cycles.
  logic force_busy = 1'b0;
  int   busy_cnt   = 0;
  int   cyc        = 0;
  assign bus.tx_busy = force_busy || (busy_cnt != 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.tx_data_valid)  busy_cnt <= FRAME;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  logic [7:0] got_q[$];
  int         pcyc_q[$];
  int         busy_viol = 0;

  always @(negedge clk) begin
    if (bus.tx_data_valid) begin
      got_q.push_back(bus.tx_data);
      pcyc_q.push_back(cyc);
      if (bus.tx_busy) busy_viol++;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [7:0] d);
    bus.wr_data  = d;
    bus.wr_valid = 1'b1;
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wr_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    got_q.delete();
    pcyc_q.delete();
  endtask

  task automatic wait_pulses(input int n, input string tag);
    int k = 0;
    while (got_q.size() < n && k < 400) begin
      step();
      k++;
    end
    chk({tag, "_pulses"}, got_q.size(), n);
  endtask

  task automatic settle();
    repeat (FRAME + 6) step();
  endtask

  initial begin
    bus.wr_data  = '0;
    bus.wr_valid = 1'b0;

    // Reset values
    do_reset();
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_valid", bus.tx_data_valid, 1'b0);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_overflow", bus.overflow, 1'b0);
    chk("rst_wr_ready", bus.wr_ready, 1'b1);

    // Single byte, 2-cycle latency
    write(8'hA5);
    chk("t1_count_after_wr", bus.fifo_count, 1);
    chk("t1_valid_n", bus.tx_data_valid, 1'b0);
    step();
    chk("t1_valid_n1", bus.tx_data_valid, 1'b1);
    chk("t1_tx_data", bus.tx_data, 8'hA5);
    chk("t1_count_pop", bus.fifo_count, 0);
    step();
    chk("t1_valid_one_cycle", bus.tx_data_valid, 1'b0);
    chk("t1_tx_data_hold", bus.tx_data, 8'hA5);
    settle();
    chk("t1_single_pulse", got_q.size(), 1);

    // Three bytes paced on tx_busy: gap = FRAME + 3 cycles
    got_q.delete();
    pcyc_q.delete();
    write(8'h11);
    write(8'h22);
    write(8'h33);
    wait_pulses(3, "t2");
    settle();
    chk("t2_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("t2_byte0", got_q[0], 8'h11);
      chk("t2_byte1", got_q[1], 8'h22);
      chk("t2_byte2", got_q[2], 8'h33);
      chk("t2_gap01", pcyc_q[1] - pcyc_q[0], FRAME + 3);
      chk("t2_gap12", pcyc_q[2] - pcyc_q[1], FRAME + 3);
    end
    chk("t2_no_pulse_while_busy", busy_viol, 0);

    // Fill, overflow, drain
    do_reset();
    force_busy = 1'b1;
    for (int i = 0; i < 8; i++) write(8'(8'h80 + i));
    chk("t3_full_count", bus.fifo_count, 8);
    chk("t3_full_wr_ready", bus.wr_ready, 1'b0);
    chk("t3_no_overflow_yet", bus.overflow, 1'b0);
    write(8'hEE);
    chk("t3_overflow", bus.overflow, 1'b1);
    chk("t3_count_kept", bus.fifo_count, 8);
    chk("t3_wr_ready", bus.wr_ready, 1'b0);
    force_busy = 1'b0;
    wait_pulses(8, "t3");
    settle();
    chk("t3_total", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      chk($sformatf("t3_byte%0d", i), got_q[i], 8'(8'h80 + i));
    chk("t3_overflow_sticky", bus.overflow, 1'b1);
    chk("t3_drained", bus.fifo_count, 0);

    // Write coinciding with the ISSUE pop while full is refused
    do_reset();
    chk("t4_overflow_cleared", bus.overflow, 1'b0);
    force_busy = 1'b1;
    for (int i = 0; i < 8; i++) write(8'(8'h40 + i));
    chk("t4_full", bus.fifo_count, 8);
    bus.wr_data  = 8'h99;
    bus.wr_valid = 1'b1;
    force_busy   = 1'b0;
    step();
    bus.wr_valid = 1'b0;
    chk("t4_count_7", bus.fifo_count, 7);
    chk("t4_valid", bus.tx_data_valid, 1'b1);
    chk("t4_tx_data", bus.tx_data, 8'h40);
    chk("t4_overflow", bus.overflow, 1'b1);
    chk("t4_wr_ready", bus.wr_ready, 1'b1);
    wait_pulses(8, "t4");
    settle();
    chk("t4_total", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      chk($sformatf("t4_byte%0d", i), got_q[i], 8'(8'h40 + i));

    // tx_busy held high before the write
    do_reset();
    force_busy = 1'b1;
    write(8'h5A);
    repeat (5) step();
    chk("t5_no_pulse", got_q.size(), 0);
    chk("t5_count", bus.fifo_count, 1);
    force_busy = 1'b0;
    step();
    chk("t5_valid", bus.tx_data_valid, 1'b1);
    chk("t5_tx_data", bus.tx_data, 8'h5A);
    settle();

    // Reset during WAIT_DONE with 4 bytes queued
    do_reset();
    for (int i = 0; i < 5; i++) write(8'(8'h61 + i));
    repeat (3) step();
    chk("t6_queued", bus.fifo_count, 4);
    chk("t6_busy", bus.tx_busy, 1'b1);
    rst = 1'b1;
    step();
    chk("t6_rst_tx_data", bus.tx_data, 8'h00);
    chk("t6_rst_valid", bus.tx_data_valid, 1'b0);
    chk("t6_rst_count", bus.fifo_count, 0);
    chk("t6_rst_overflow", bus.overflow, 1'b0);
    chk("t6_rst_wr_ready", bus.wr_ready, 1'b1);
    rst = 1'b0;
    repeat (40) step();
    chk("t6_no_more_pulses", got_q.size(), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
